// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: state encoding, funct3 codes,
// and the access-size / legality decode helpers.
package lsu_pkg;

    // FSM state encoding
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StAcc0 = 3'd1;
    localparam logic [2:0] StAcc1 = 3'd2;
    localparam logic [2:0] StWait = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    // RV32I load/store funct3 codes
    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    // Number of bytes touched by an access; code 11 is illegal and only
    // reaches here on a request that never drives the memory.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        logic [2:0] n;
        unique case (funct3[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic req_illegal(input logic       rd,
                                         input logic       wr,
                                         input logic [2:0] funct3);
        logic bad;
        if (rd && wr) begin
            bad = 1'b1;
        end else if (rd) begin
            bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else begin
            bad = !((funct3 == F3Sb) || (funct3 == F3Sh) || (funct3 == F3Sw));
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: places store data and byte enables into a
// 64-bit {second, first} word pair and extracts/extends load data from it.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [63:0] rpair,
    output logic [63:0] wpair,
    output logic [7:0]  bepair,
    output logic [31:0] load_data
);

    logic [2:0]  nbytes;
    logic [3:0]  mask;
    logic [63:0] shifted;

    // Shift store data/mask up by lane, shift load pair down by lane and extend
    always_comb begin
        nbytes = size_bytes(funct3);
        unique case (nbytes)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase

        bepair  = {4'b0000, mask} << lane;
        wpair   = {32'h0, wdata} << {lane, 3'b000};
        shifted = rpair >> {lane, 3'b000};

        unique case (funct3[1:0])
            2'b00: begin
                load_data = funct3[2] ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                load_data = funct3[2] ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: load_data = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a 32-bit word memory. Misaligned
// accesses that cross a word boundary are split into two word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        funct3,
    output logic              req_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              err_illegal,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-3:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    localparam int unsigned WW = ADDR_W - 2;

    logic [2:0]    state_q, state_d;
    logic [WW-1:0] word_q;
    logic [1:0]    lane_q;
    logic [2:0]    funct3_q;
    logic [31:0]   wdata_q;
    logic          load_q, store_q, cross_q, err_q;
    logic [31:0]   first_q;
    logic [31:0]   rdata_q;

    logic          accept;
    logic          acc_cross;
    logic          acc_illegal;
    logic [63:0]   rpair;
    logic [63:0]   wpair;
    logic [7:0]    bepair;
    logic [31:0]   load_data;

    // Accept-time decode of the incoming request
    always_comb begin
        accept      = (state_q == StIdle) && req_valid && (mem_read || mem_write);
        acc_cross   = (({1'b0, addr[1:0]} + size_bytes(funct3)) > 3'd4);
        acc_illegal = req_illegal(mem_read, mem_write, funct3);
        // Aligned loads see their only word in m_rdata; crossing loads pair it
        // with the first word captured during ACC1.
        rpair       = cross_q ? {m_rdata, first_q} : {32'h0, m_rdata};
    end

    lsu_align u_align (
        .lane      (lane_q),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .rpair     (rpair),
        .wpair     (wpair),
        .bepair    (bepair),
        .load_data (load_data)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = acc_illegal ? StDone : StAcc0;
            end
            StAcc0: begin
                if (cross_q)     state_d = StAcc1;
                else if (load_q) state_d = StWait;
                else             state_d = StDone;
            end
            StAcc1:  state_d = load_q ? StWait : StDone;
            StWait:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, request latch, and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            word_q   <= '0;
            lane_q   <= 2'b00;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            cross_q  <= 1'b0;
            err_q    <= 1'b0;
            first_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q   <= addr[ADDR_W-1:2];
                lane_q   <= addr[1:0];
                funct3_q <= funct3;
                wdata_q  <= wdata;
                load_q   <= mem_read;
                store_q  <= mem_write;
                cross_q  <= acc_cross;
                err_q    <= acc_illegal;
            end
            if (state_q == StAcc1) first_q <= m_rdata;
            // Only loads pass through WAIT; every other path into DONE yields 0
            if (state_q == StWait)      rdata_q <= load_data;
            else if (state_d == StDone) rdata_q <= 32'h0;
        end
    end

    // Memory-side and handshake outputs, all forced quiet while in reset
    always_comb begin
        m_req       = 1'b0;
        m_we        = 1'b0;
        m_addr      = word_q;
        m_be        = 4'b0000;
        m_wdata     = 32'h0;
        resp_valid  = 1'b0;
        err_illegal = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StAcc0: begin
                    m_req   = 1'b1;
                    m_we    = store_q;
                    m_be    = bepair[3:0];
                    m_wdata = wpair[31:0];
                end
                StAcc1: begin
                    m_req   = 1'b1;
                    m_we    = store_q;
                    m_addr  = word_q + WW'(1);
                    m_be    = bepair[7:4];
                    m_wdata = wpair[63:32];
                end
                StDone: begin
                    resp_valid  = 1'b1;
                    err_illegal = err_q;
                end
                default: ;
            endcase
        end
        req_ready = (state_q == StIdle);
        stall     = !rst && (accept || (state_q == StAcc0) || (state_q == StAcc1) ||
                             (state_q == StWait));
        rdata     = rst ? 32'h0 : rdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a word-memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [12:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  funct3 = '0;
    logic        req_ready, stall, resp_valid, err_illegal;
    logic [31:0] rdata;
    logic        m_req, m_we;
    logic [10:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;

    int passed = 0;
    int total  = 0;

    // Word memory model and backdoor preload port
    logic [31:0] mem [0:2047];
    logic        pre_we = 1'b0;
    logic [10:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    // Access log, sampled on the falling edge
    logic [10:0] log_addr [8];
    logic        log_we   [8];
    logic [3:0]  log_be   [8];
    logic [31:0] log_wd   [8];
    int          log_n = 0;

    // Results of the last request
    int          lat;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        acc_stall;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(13)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .wdata       (wdata),
        .funct3      (funct3),
        .req_ready   (req_ready),
        .stall       (stall),
        .resp_valid  (resp_valid),
        .rdata       (rdata),
        .err_illegal (err_illegal),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_be        (m_be),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (m_req) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
                end
            end
            m_rdata <= mem[m_addr];
        end
    end

    always @(negedge clk) begin
        if (m_req && log_n < 8) begin
            log_addr[log_n] = m_addr;
            log_we[log_n]   = m_we;
            log_be[log_n]   = m_be;
            log_wd[log_n]   = m_wdata;
            log_n           = log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic poke(input logic [10:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Present one request for a cycle and wait (bounded) for its response
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [12:0] a, input logic [31:0] wd);
        @(negedge clk);
        log_n     = 0;
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1 acc_stall = stall;
        @(negedge clk);
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        lat       = -1;
        got_rdata = 32'hxxxx_xxxx;
        got_err   = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            if (resp_valid) begin
                lat       = c;
                got_rdata = rdata;
                got_err   = err_illegal;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int resp_seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_mreq", {31'h0, m_req}, 32'h0);
        chk("rst_resp", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);

        // LB addr 1, aligned, sign-extended
        poke(11'h000, 32'h8899AABB);
        do_req(1'b1, 1'b0, 3'b000, 13'h0001, 32'h0);
        chk("lb_stall", {31'h0, acc_stall}, 32'h1);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_rdata", got_rdata, 32'hFFFFFFAA);
        chk("lb_nreq", 32'(log_n), 32'd1);
        chk("lb_addr", {21'h0, log_addr[0]}, 32'h0);

        // LHU addr 3, crossing
        poke(11'h000, 32'h11223344);
        poke(11'h001, 32'h55667788);
        do_req(1'b1, 1'b0, 3'b101, 13'h0003, 32'h0);
        chk("lhu_lat", 32'(lat), 32'd4);
        chk("lhu_rdata", got_rdata, 32'h00008811);
        chk("lhu_nreq", 32'(log_n), 32'd2);
        chk("lhu_addr0", {21'h0, log_addr[0]}, 32'h0);
        chk("lhu_addr1", {21'h0, log_addr[1]}, 32'h1);

        // SW addr 2, crossing store
        do_req(1'b0, 1'b1, 3'b010, 13'h0002, 32'hDEADBEEF);
        chk("sw_lat", 32'(lat), 32'd3);
        chk("sw_rdata", got_rdata, 32'h0);
        chk("sw_nreq", 32'(log_n), 32'd2);
        chk("sw_we0", {31'h0, log_we[0]}, 32'h1);
        chk("sw_be0", {28'h0, log_be[0]}, 32'hC);
        chk("sw_wd0", log_wd[0], 32'hBEEF0000);
        chk("sw_be1", {28'h0, log_be[1]}, 32'h3);
        chk("sw_wd1", log_wd[1], 32'h0000DEAD);
        chk("sw_mem0", mem[0], 32'hBEEF3344);
        chk("sw_mem1", mem[1], 32'h5566DEAD);

        // LW addr 2 reads the crossing store back
        do_req(1'b1, 1'b0, 3'b010, 13'h0002, 32'h0);
        chk("lw2_lat", 32'(lat), 32'd4);
        chk("lw2_rdata", got_rdata, 32'hDEADBEEF);

        // Illegal load funct3=011
        do_req(1'b1, 1'b0, 3'b011, 13'h0000, 32'h0);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_err", {31'h0, got_err}, 32'h1);
        chk("ill_rdata", got_rdata, 32'h0);
        chk("ill_nreq", 32'(log_n), 32'd0);

        // LW at top of memory wraps to word 0
        poke(11'h7FF, 32'hCAFEF00D);
        do_req(1'b1, 1'b0, 3'b010, 13'h1FFE, 32'h0);
        chk("wrap_lat", 32'(lat), 32'd4);
        chk("wrap_addr0", {21'h0, log_addr[0]}, 32'h7FF);
        chk("wrap_addr1", {21'h0, log_addr[1]}, 32'h000);
        chk("wrap_rdata", got_rdata, 32'h3344CAFE);

        // Extension variants on word0 = BEEF3344
        do_req(1'b1, 1'b0, 3'b001, 13'h0000, 32'h0);
        chk("lh0_rdata", got_rdata, 32'h00003344);
        do_req(1'b1, 1'b0, 3'b001, 13'h0002, 32'h0);
        chk("lh2_rdata", got_rdata, 32'hFFFFBEEF);
        do_req(1'b1, 1'b0, 3'b100, 13'h0003, 32'h0);
        chk("lbu_rdata", got_rdata, 32'h000000BE);
        chk("lbu_err", {31'h0, got_err}, 32'h0);
        @(negedge clk);
        chk("hold_rdata", rdata, 32'h000000BE);
        chk("hold_resp", {31'h0, resp_valid}, 32'h0);

        // SB addr 1, aligned store
        do_req(1'b0, 1'b1, 3'b000, 13'h0001, 32'h000000A5);
        chk("sb_lat", 32'(lat), 32'd2);
        chk("sb_be", {28'h0, log_be[0]}, 32'h2);
        chk("sb_wd", log_wd[0], 32'h0000A500);
        chk("sb_mem0", mem[0], 32'hBEEFA544);

        // Illegal store funct3 and read+write together
        do_req(1'b0, 1'b1, 3'b100, 13'h0000, 32'h0);
        chk("ills_err", {31'h0, got_err}, 32'h1);
        chk("ills_nreq", 32'(log_n), 32'd0);
        do_req(1'b1, 1'b1, 3'b010, 13'h0000, 32'h0);
        chk("illrw_err", {31'h0, got_err}, 32'h1);
        chk("illrw_lat", 32'(lat), 32'd1);

        // Request with neither read nor write is ignored
        @(negedge clk);
        req_valid = 1'b1;
        funct3    = 3'b010;
        #1 chk("nop_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        resp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid || stall) resp_seen++;
            @(negedge clk);
        end
        chk("nop_resp", 32'(resp_seen), 32'd0);
        chk("nop_ready", {31'h0, req_ready}, 32'h1);

        // Reset during ACC1 aborts the crossing load
        @(negedge clk);
        req_valid = 1'b1;
        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr      = 13'h0003;
        @(negedge clk);
        req_valid = 1'b0;
        mem_read  = 1'b0;
        chk("abort_acc0_req", {31'h0, m_req}, 32'h1);
        chk("abort_ready_busy", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("abort_acc1_addr", {21'h0, m_addr}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mreq", {31'h0, m_req}, 32'h0);
        chk("abort_resp", {31'h0, resp_valid}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        resp_seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid || m_req) resp_seen++;
            @(negedge clk);
        end
        chk("abort_quiet", 32'(resp_seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 13, is the byte-address width of requests.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  the MEM-stage pipeline presents a request.
REQ-005 mem_read / mem_write  in  1 each  load or store request.
REQ-006 addr  in  ADDR_W  byte address.
REQ-007 wdata  in  32  store data, LSB-aligned.
REQ-008 funct3  in  3  RV32I load/store size and signedness code.
REQ-009 req_ready  out  1  high only in IDLE.
REQ-010 stall  out  1  freezes the pipeline while the access is in flight.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  extended load result.
REQ-013 err_illegal  out  1  illegal-request pulse, coincident with resp_valid.
REQ-014 m_req  out  1  word-memory access strobe.
REQ-015 m_we  out  1  write enable for the word memory.
REQ-016 m_addr  out  ADDR_W-2  word address.
REQ-017 m_be  out  4  byte enables for the word memory.
REQ-018 m_wdata  out  32  write data for the word memory.
REQ-019 m_rdata  in  32  read data, valid the cycle after a read m_req.

Function
REQ-020 A request is accepted when req_valid=1, (mem_read|mem_write)=1 and the state is IDLE; the request fields are latched at that edge (cycle T).
REQ-021 req_valid with mem_read=mem_write=0 is ignored: no stall, no response.
REQ-022 stall = (IDLE and accept condition) or state in {ACC0, ACC1, WAIT}; stall=0 in DONE.
REQ-023 Size: funct3[1:0] 00=1 byte, 01=2 bytes, 10=4 bytes; lane = addr[1:0]; the access is crossing when lane+size>4.
REQ-024 The request is illegal for load funct3 011/110/111, store funct3 other than 000/001/010, or mem_read=mem_write=1.
REQ-025 An illegal request goes IDLE->DONE with no m_req; DONE drives err_illegal=1 and rdata=0.
REQ-026 IDLE: on accept go to ACC0.
REQ-027 ACC0: m_req=1, m_addr=addr[ADDR_W-1:2]; go to ACC1 if crossing, else WAIT for a load, else DONE.
REQ-028 ACC1: m_req=1, m_addr=first word+1, wrapping from all-ones to 0; capture the ACC0 read data; go to WAIT for a load, else DONE.
REQ-029 WAIT: capture the last m_rdata; go to DONE.
REQ-030 DONE: resp_valid=1 for one cycle; go to IDLE.
REQ-031 Latency from accept T to resp_valid: aligned load T+3, crossing load T+4, aligned store T+2, crossing store T+3, illegal T+1.
REQ-032 Store data: m_wdata/m_be equal the data/mask shifted left by lane*8/lane within a 64-bit {second, first} pair; ACC0 drives the low half, ACC1 the high half.
REQ-033 Load data: ({second, first} >> lane*8) truncated to size.
REQ-034 Load extension: funct3 000/001 sign-extend; 100/101 zero-extend; 010 passes 32 bits.
REQ-035 rdata=0 for stores; rdata holds its value outside DONE.
REQ-036 m_we=mem_write during ACC0/ACC1; m_req=0, m_we=0 and m_be=0 in all other states.

Reset
REQ-037 While rst=1: state=IDLE; m_req, m_we, m_be, resp_valid, err_illegal, stall = 0; rdata=0; req_ready=1 on the first cycle after release.
REQ-038 rst asserted mid-operation aborts the access: no resp_valid for it, and m_req is 0 from the next cycle.

Structure
REQ-039 Package lsu_pkg holds the funct3 constants, the state enum {IDLE, ACC0, ACC1, WAIT, DONE}, and the size-decode function.
REQ-040 Sub-module lsu_align (combinational) performs the lane shift, byte-enable generation, and load extraction.

Verification
REQ-041 Word0=0x8899AABB; LB addr 1 -> one m_req at word 0; rdata=0xFFFFFFAA; resp at T+3.
REQ-042 Word0=0x11223344, word1=0x55667788; LHU addr 3 -> m_req at words 0 then 1; rdata=0x00008811; resp at T+4.
REQ-043 SW addr 2, wdata 0xDEADBEEF -> word0 be=1100 data=0xBEEF0000, then word1 be=0011 data=0x0000DEAD; resp at T+3.
REQ-044 Load with funct3=011 -> no m_req; resp_valid=err_illegal=1 at T+1; rdata=0.
REQ-045 LW addr 0x1FFE -> m_addr 0x7FF then 0x000; rdata assembled from both words.
REQ-046 rst pulsed during ACC1 -> IDLE next cycle; no resp_valid; req_ready=1 after release.
